key_decoder: RTL and testbench

KEY_DECODER -- requirements
Module: key_decoder

---
 rtl/key_decoder.sv | 194 +++++++++++++++++++
 tb/tb_key_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_decoder.sv
// PS/2 scan-code decoder: resynchronises an asynchronous parallel scan code,
// accepts each new byte once it has been stable, parses E0/F0 prefixes and
// tracks direction keys (arrows and WASD) plus the Enter start key.
module key_decoder #(
   parameter int STABLE_CYCLES  = 16,
   parameter int PREFIX_TIMEOUT = 1000000
) (
   input  logic       clk50,
   input  logic       reset,
   input  logic [7:0] code,
   output logic       byte_strobe,
   output logic [3:0] held,
   output logic [1:0] dir,
   output logic       dir_valid,
   output logic       start_pulse
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   logic [7:0]    sync1_q, sync1_d;
   logic [7:0]    code_s_q, code_s_d;
   logic [7:0]    prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    last_byte_q, last_byte_d;
   logic          strobe_q, strobe_d;
   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [3:0]    held_q, held_d;
   logic [1:0]    dir_q, dir_d;
   logic          dir_valid_q, dir_valid_d;
   logic          start_q, start_d;

   logic          ext_s;
   logic          brk_s;
   logic [2:0]    map_s;
   logic [3:0]    mask_s;

   // Map a final scan byte to {hit, direction index}; index 0 up .. 3 right.
   function automatic logic [2:0] dir_lookup(input logic [7:0] b, input logic ext);
      logic [2:0] r;
      r = 3'b000;
      if (ext) begin
         case (b)
            8'h75:   r = 3'b100;
            8'h72:   r = 3'b101;
            8'h6B:   r = 3'b110;
            8'h74:   r = 3'b111;
            default: r = 3'b000;
         endcase
      end else begin
         case (b)
            8'h1D:   r = 3'b100;
            8'h1B:   r = 3'b101;
            8'h1C:   r = 3'b110;
            8'h23:   r = 3'b111;
            default: r = 3'b000;
         endcase
      end
      return r;
   endfunction

   // Synchronizer, stability counter and byte acceptance.
   always_comb begin
      sync1_d     = code;
      code_s_d    = sync1_q;
      prev_d      = code_s_q;
      cnt_d       = cnt_q;
      last_byte_d = last_byte_q;
      strobe_d    = 1'b0;
      if (code_s_q != prev_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
         // Accept only on the transition into saturation, and only new values.
         if ((cnt_q == CNT_LAST) && (code_s_q != last_byte_q)) begin
            strobe_d    = 1'b1;
            last_byte_d = code_s_q;
         end else begin
            strobe_d    = 1'b0;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Prefix parser, prefix timeout and key-state update; the accepted byte
   // sits in last_byte_q during the byte_strobe cycle.
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      held_d      = held_q;
      dir_d       = dir_q;
      dir_valid_d = dir_valid_q;
      start_d     = 1'b0;
      ext_s       = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
      brk_s       = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
      map_s       = dir_lookup(last_byte_q, ext_s);
      mask_s      = 4'b1000 >> map_s[1:0];
      if (strobe_q) begin
         tmr_d = {TW{1'b0}};
         case (last_byte_q)
            8'hE0: begin
               case (state_q)
                  ST_IDLE: state_d = ST_EXT;
                  ST_BRK:  state_d = ST_EXT_BRK;
                  default: state_d = state_q;
               endcase
            end
            8'hF0: begin
               case (state_q)
                  ST_IDLE: state_d = ST_BRK;
                  ST_EXT:  state_d = ST_EXT_BRK;
                  default: state_d = state_q;
               endcase
            end
            default: begin
               state_d = ST_IDLE;
               if (map_s[2]) begin
                  if (brk_s) begin
                     held_d = held_q & ~mask_s;
                  end else begin
                     held_d      = held_q | mask_s;
                     dir_d       = map_s[1:0];
                     dir_valid_d = 1'b1;
                  end
               end else if (!ext_s && !brk_s && (last_byte_q == 8'h5A)) begin
                  start_d = 1'b1;
               end else begin
                  start_d = 1'b0;
               end
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         // A dangling prefix is dropped silently when its timer expires.
         if (tmr_q == TMO_LAST) begin
            state_d = ST_IDLE;
            tmr_d   = {TW{1'b0}};
         end else begin
            tmr_d   = tmr_q + TW'(1);
         end
      end else begin
         tmr_d = {TW{1'b0}};
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk50) begin
      if (reset) begin
         sync1_q     <= 8'h00;
         code_s_q    <= 8'h00;
         prev_q      <= 8'h00;
         cnt_q       <= {CW{1'b0}};
         last_byte_q <= 8'h00;
         strobe_q    <= 1'b0;
         state_q     <= ST_IDLE;
         tmr_q       <= {TW{1'b0}};
         held_q      <= 4'b0000;
         dir_q       <= 2'd0;
         dir_valid_q <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         code_s_q    <= code_s_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         last_byte_q <= last_byte_d;
         strobe_q    <= strobe_d;
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         held_q      <= held_d;
         dir_q       <= dir_d;
         dir_valid_q <= dir_valid_d;
         start_q     <= start_d;
      end
   end

   assign byte_strobe = strobe_q;
   assign held        = held_q;
   assign dir         = dir_q;
   assign dir_valid   = dir_valid_q;
   assign start_pulse = start_q;

endmodule

// File: tb/tb_key_decoder.sv
// Scoreboard bench for key_decoder: stimulus pushes the expected key state for
// each byte that should be accepted; a monitor pops and compares it one cycle
// after every byte_strobe.
module tb_key_decoder;

   localparam int STB = 16;
   localparam int TMO = 200;

   logic       clk50 = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] code  = 8'h00;
   logic       byte_strobe;
   logic [3:0] held;
   logic [1:0] dir;
   logic       dir_valid;
   logic       start_pulse;

   typedef struct packed {
      logic [3:0] held;
      logic [1:0] dir;
      logic       valid;
      logic       start;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   lat;

   key_decoder #(.STABLE_CYCLES(STB), .PREFIX_TIMEOUT(TMO)) dut (
      .clk50       (clk50),
      .reset       (reset),
      .code        (code),
      .byte_strobe (byte_strobe),
      .held        (held),
      .dir         (dir),
      .dir_valid   (dir_valid),
      .start_pulse (start_pulse)
   );

   always #10 clk50 = ~clk50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one byte for 40 cycles; optionally push its expected outcome and
   // report how many edges it took for held to change.
   task automatic send(input logic [7:0] b, input bit expect_strobe,
                       input logic [3:0] h, input logic [1:0] d, input logic v,
                       input logic s, output int latency);
      exp_t       e;
      logic [3:0] h0;
      @(negedge clk50);
      h0   = held;
      code = b;
      if (expect_strobe) begin
         e.held  = h;
         e.dir   = d;
         e.valid = v;
         e.start = s;
         exp_q.push_back(e);
      end
      latency = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk50);
         #1;
         if (latency < 0 && held !== h0) latency = i;
      end
   endtask

   task automatic hold_code(input logic [7:0] b, input int cycles);
      @(negedge clk50);
      code = b;
      repeat (cycles) @(posedge clk50);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_held"}, held, 4'b0000);
      check({name, "_dir"}, dir, 2'd0);
      check({name, "_dir_valid"}, dir_valid, 1'b0);
      check({name, "_strobe"}, byte_strobe, 1'b0);
      check({name, "_start"}, start_pulse, 1'b0);
   endtask

   // Monitor: on each byte_strobe pop the expected state and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk50);
         #1;
         if (byte_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_strobe: got byte_strobe=1 expected 0 at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               @(posedge clk50);
               #1;
               check("strobe_width", byte_strobe, 1'b0);
               check("held", held, e.held);
               check("dir", dir, e.dir);
               check("dir_valid", dir_valid, e.valid);
               check("start_pulse", start_pulse, e.start);
               @(posedge clk50);
               #1;
               check("start_width", start_pulse, 1'b0);
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      bit seen;
      repeat (3) @(posedge clk50);
      #1;
      check_all_zero("reset");
      @(negedge clk50);
      reset = 1'b0;
      repeat (20) @(posedge clk50);

      // E0,75 press: up held, dir up; latency to held update checked.
      send(8'h00, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, lat);
      send(8'hE0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, lat);
      send(8'h75, 1'b1, 4'b1000, 2'd0, 1'b1, 1'b0, lat);
      n_checks++;
      if (lat < 18 || lat > 20) begin
         n_fail++;
         $display("FAIL latency: got %0d expected 18..20", lat);
      end

      // E0,F0,75 release.
      send(8'hE0, 1'b1, 4'b1000, 2'd0, 1'b1, 1'b0, lat);
      send(8'hF0, 1'b1, 4'b1000, 2'd0, 1'b1, 1'b0, lat);
      send(8'h75, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, lat);

      // WASD left, right, release left.
      send(8'h1C, 1'b1, 4'b0010, 2'd2, 1'b1, 1'b0, lat);
      send(8'h23, 1'b1, 4'b0011, 2'd3, 1'b1, 1'b0, lat);
      send(8'hF0, 1'b1, 4'b0011, 2'd3, 1'b1, 1'b0, lat);
      send(8'h1C, 1'b1, 4'b0001, 2'd3, 1'b1, 1'b0, lat);

      // Short glitches and a return to the last byte: nothing accepted.
      hold_code(8'h75, 5);
      hold_code(8'h12, 5);
      hold_code(8'h75, 5);
      hold_code(8'h1C, 40);
      #1;
      check("glitch_held", held, 4'b0001);
      check("glitch_dir", dir, 2'd3);
      check("glitch_valid", dir_valid, 1'b1);

      // E0 prefix times out, so 1D decodes non-extended (up).
      send(8'hE0, 1'b1, 4'b0001, 2'd3, 1'b1, 1'b0, lat);
      repeat (TMO + 100) @(posedge clk50);
      send(8'h1D, 1'b1, 4'b1001, 2'd0, 1'b1, 1'b0, lat);

      // Enter make pulses; break, extended and unmapped bytes are ignored.
      send(8'h5A, 1'b1, 4'b1001, 2'd0, 1'b1, 1'b1, lat);
      send(8'hF0, 1'b1, 4'b1001, 2'd0, 1'b1, 1'b0, lat);
      send(8'h5A, 1'b1, 4'b1001, 2'd0, 1'b1, 1'b0, lat);
      send(8'hE0, 1'b1, 4'b1001, 2'd0, 1'b1, 1'b0, lat);
      send(8'h5A, 1'b1, 4'b1001, 2'd0, 1'b1, 1'b0, lat);
      send(8'hAA, 1'b1, 4'b1001, 2'd0, 1'b1, 1'b0, lat);

      // Reset shortly after an F0 prefix; 5A afterwards is a fresh make.
      @(negedge clk50);
      code = 8'hF0;
      begin
         exp_t e;
         e.held  = 4'b1001;
         e.dir   = 2'd0;
         e.valid = 1'b1;
         e.start = 1'b0;
         exp_q.push_back(e);
      end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk50);
         #1;
         if (byte_strobe === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL f0_strobe: got no byte_strobe expected one within 40 cycles");
      end
      repeat (3) @(posedge clk50);
      @(negedge clk50);
      reset = 1'b1;
      code  = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk50);
         #1;
         check_all_zero("midreset");
      end
      begin
         exp_t e;
         e.held  = 4'b0000;
         e.dir   = 2'd0;
         e.valid = 1'b0;
         e.start = 1'b1;
         exp_q.push_back(e);
      end
      @(negedge clk50);
      reset = 1'b0;
      repeat (40) @(posedge clk50);

      repeat (10) @(posedge clk50);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
